// File: rtl/bram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bram_arb_pkg
// Shared defaults and types for the two-port Bram arbiter.
//   WORD_LENGTH : data width of one Bram word
//   ADDR_WIDTH  : Bram address width
//   MEM_DEPTH   : number of valid Bram words (legal addresses 0..MEM_DEPTH-1)
//   MAX_BURST   : beats one owner may take back-to-back while the other waits
//   arbState_t  : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int WORD_LENGTH = 16;
  localparam int ADDR_WIDTH  = 17;
  localparam int MEM_DEPTH   = 125001;
  localparam int MAX_BURST   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_t;

  // One-hot port strobe from a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bram_arb_rsp.sv
// -----------------------------------------------------------------------------
// bram_arb_rsp
// One-cycle response tracker. A beat accepted in cycle N that needs a
// response (any read, or any out-of-range access) is remembered here and
// reported to its port in cycle N+1, when the Bram read data is valid.
// Ports:
//   clock, resetN   : clock, synchronous active-low reset
//   issue_i         : a beat needing a response is accepted this cycle
//   isRead_i        : that beat is a read
//   isErr_i         : that beat addressed beyond the memory
//   port_i          : port index of that beat
//   bramDataOut_i   : Bram read data (valid the cycle after the read)
//   rspValid_o      : per-port read-data strobe
//   rspErr_o        : per-port out-of-range strobe
//   rspData_o       : read data, zero for errors and when idle
// -----------------------------------------------------------------------------
module bram_arb_rsp #(
  parameter int WORD_LENGTH = bram_arb_pkg::WORD_LENGTH
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   issue_i,
  input  logic                   isRead_i,
  input  logic                   isErr_i,
  input  logic                   port_i,
  input  logic [WORD_LENGTH-1:0] bramDataOut_i,
  output logic [1:0]             rspValid_o,
  output logic [1:0]             rspErr_o,
  output logic [WORD_LENGTH-1:0] rspData_o
);

  import bram_arb_pkg::*;

  logic pend_q;
  logic read_q;
  logic err_q;
  logic port_q;
  logic live;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= issue_i;
    end
  end

  // Beat attributes only matter while pend_q is set, so they need no reset.
  always_ff @(posedge clock) begin
    if (issue_i) begin
      read_q <= isRead_i;
      err_q  <= isErr_i;
      port_q <= port_i;
    end
  end

  // Outputs are also gated by resetN so a response pending when reset
  // arrives is never shown.
  assign live = resetN & pend_q;

  always_comb begin
    rspValid_o = 2'b00;
    rspErr_o   = 2'b00;
    rspData_o  = '0;
    if (live) begin
      if (read_q) begin
        rspValid_o = port_onehot(port_q);
      end
      if (err_q) begin
        rspErr_o = port_onehot(port_q);
      end
      if (read_q && !err_q) begin
        rspData_o = bramDataOut_i;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// -----------------------------------------------------------------------------
// bram_arbiter
// Two-port arbiter in front of a single-port Bram. One port owns the Bram at
// a time (IDLE -> OWN0/OWN1); the owner transfers one beat per cycle while
// its reqValid is high. Reads return data on rspData one cycle after they
// are accepted; out-of-range beats never reach the Bram and raise rspErr.
//
// Build option:
//   BRAM_ARB_ROUND_ROBIN_EN  defined   : IDLE grants the port not granted most
//                                        recently, and an owner is switched
//                                        out after MAX_BURST beats when the
//                                        other port is waiting.
//                            undefined : port 0 always wins and may hold the
//                                        Bram indefinitely.
// Ports:
//   clock, resetN              : clock, synchronous active-low reset
//   reqValid/reqWrite[1:0]     : per-port request and direction (1 = write)
//   reqAddr0/1, reqData0/1     : per-port address and write data
//   reqReady[1:0]              : per-port accept (only the owner)
//   rspValid/rspErr[1:0]       : per-port read strobe / out-of-range strobe
//   rspData                    : shared read data
//   bramEnable/WriteEnable     : Bram controls
//   bramAddress, bramDataIn    : Bram address and write data
//   bramDataOut                : Bram read data, one cycle after the read
// -----------------------------------------------------------------------------
module bram_arbiter #(
  parameter int WORD_LENGTH = bram_arb_pkg::WORD_LENGTH,
  parameter int ADDR_WIDTH  = bram_arb_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH   = bram_arb_pkg::MEM_DEPTH,
  parameter int MAX_BURST   = bram_arb_pkg::MAX_BURST
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [1:0]             reqValid,
  input  logic [1:0]             reqWrite,
  input  logic [ADDR_WIDTH-1:0]  reqAddr0,
  input  logic [ADDR_WIDTH-1:0]  reqAddr1,
  input  logic [WORD_LENGTH-1:0] reqData0,
  input  logic [WORD_LENGTH-1:0] reqData1,
  output logic [1:0]             reqReady,
  output logic [1:0]             rspValid,
  output logic [WORD_LENGTH-1:0] rspData,
  output logic [1:0]             rspErr,
  output logic                   bramEnable,
  output logic                   bramWriteEnable,
  output logic [ADDR_WIDTH-1:0]  bramAddress,
  output logic [WORD_LENGTH-1:0] bramDataIn,
  input  logic [WORD_LENGTH-1:0] bramDataOut
);

  import bram_arb_pkg::*;

  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_W    = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0]          BURST_LAST = 4'(MAX_BURST - 1);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  localparam bit                  BURST_LIMIT_EN = 1'b1;
`else
  localparam bit                  BURST_LIMIT_EN = 1'b0;
`endif

  arbState_t              state_q, state_d;
  logic [3:0]             burstCnt_q, burstCnt_d;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // Port granted most recently; reset to 1 so port 0 has first priority.
  logic                   lastOwner_q, lastOwner_d;
`endif

  logic                   owner;
  logic                   curValid;
  logic                   curWrite;
  logic [ADDR_WIDTH-1:0]  curAddr;
  logic [WORD_LENGTH-1:0] curData;
  logic                   otherReq;
  logic                   accept;
  logic                   inRange;
  logic                   issue;
  logic                   burstEnd;
  logic                   grantPort;

  // Current owner's request, selected by state (OWN1 -> port 1).
  assign owner    = (state_q == OWN1);
  assign curValid = reqValid[owner];
  assign curWrite = reqWrite[owner];
  assign curAddr  = owner ? reqAddr1 : reqAddr0;
  assign curData  = owner ? reqData1 : reqData0;
  assign otherReq = reqValid[~owner];

  always_comb begin
    reqReady = 2'b00;
    if (resetN) begin
      case (state_q)
        OWN0:    reqReady = 2'b01;
        OWN1:    reqReady = 2'b10;
        default: reqReady = 2'b00;
      endcase
    end
  end

  assign accept   = |(reqValid & reqReady);
  assign inRange  = ({1'b0, curAddr} < DEPTH_W);
  assign issue    = accept & inRange;
  assign burstEnd = BURST_LIMIT_EN & accept & (burstCnt_q == BURST_LAST) & otherReq;

  // IDLE winner: with both requesting, the port not granted last time.
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  assign grantPort = (reqValid == 2'b11) ? ~lastOwner_q : reqValid[1];
`else
  assign grantPort = ~reqValid[0];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|reqValid) begin
          state_d = grantPort ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (!curValid) begin
          if (otherReq) begin
            state_d = owner ? OWN0 : OWN1;
          end else begin
            state_d = IDLE;
          end
        end else if (burstEnd) begin
          state_d = owner ? OWN0 : OWN1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burstCnt_d = burstCnt_q;
    if (state_d != state_q) begin
      burstCnt_d = 4'd0;
    end else if (accept) begin
      burstCnt_d = burstCnt_q + 4'd1;
    end
  end

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    lastOwner_d = lastOwner_q;
    if ((state_d != state_q) && (state_d != IDLE)) begin
      lastOwner_d = (state_d == OWN1);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q     <= IDLE;
      burstCnt_q  <= 4'd0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      lastOwner_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      burstCnt_q  <= burstCnt_d;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      lastOwner_q <= lastOwner_d;
`endif
    end
  end

  // Bram side is driven only by a legal accepted beat, zero otherwise.
  always_comb begin
    bramEnable      = issue;
    bramWriteEnable = issue & curWrite;
    bramAddress     = '0;
    bramDataIn      = '0;
    if (issue) begin
      bramAddress = curAddr;
      bramDataIn  = curData;
    end
  end

  // Reads always answer; writes answer only when they are out of range.
  bram_arb_rsp #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_rsp (
    .clock         (clock),
    .resetN        (resetN),
    .issue_i       (accept & (~curWrite | ~inRange)),
    .isRead_i      (~curWrite),
    .isErr_i       (~inRange),
    .port_i        (owner),
    .bramDataOut_i (bramDataOut),
    .rspValid_o    (rspValid),
    .rspErr_o      (rspErr),
    .rspData_o     (rspData)
  );

endmodule

// File: tb/tb_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_arbiter
// Directed bench for bram_arbiter with a small Bram model. Unwritten Bram
// words read back as 16'hA000 + address[9:0].
// -----------------------------------------------------------------------------
module tb_bram_arbiter;

  import bram_arb_pkg::*;

  localparam int WL = 16;
  localparam int AW = 17;

  logic          clock = 1'b0;
  logic          resetN;
  logic [1:0]    reqValid;
  logic [1:0]    reqWrite;
  logic [AW-1:0] reqAddr0, reqAddr1;
  logic [WL-1:0] reqData0, reqData1;
  logic [1:0]    reqReady;
  logic [1:0]    rspValid;
  logic [WL-1:0] rspData;
  logic [1:0]    rspErr;
  logic          bramEnable, bramWriteEnable;
  logic [AW-1:0] bramAddress;
  logic [WL-1:0] bramDataIn;
  logic [WL-1:0] bramDataOut;

  always #5 clock = ~clock;

  bram_arbiter dut (
    .clock           (clock),
    .resetN          (resetN),
    .reqValid        (reqValid),
    .reqWrite        (reqWrite),
    .reqAddr0        (reqAddr0),
    .reqAddr1        (reqAddr1),
    .reqData0        (reqData0),
    .reqData1        (reqData1),
    .reqReady        (reqReady),
    .rspValid        (rspValid),
    .rspData         (rspData),
    .rspErr          (rspErr),
    .bramEnable      (bramEnable),
    .bramWriteEnable (bramWriteEnable),
    .bramAddress     (bramAddress),
    .bramDataIn      (bramDataIn),
    .bramDataOut     (bramDataOut)
  );

  // Bram model: 1024 words with written flags, one-cycle read latency.
  logic [WL-1:0] mem   [0:1023];
  logic          wflag [0:1023];

  always @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < 1024; i++) wflag[i] <= 1'b0;
    end else if (bramEnable) begin
      if (bramWriteEnable) begin
        mem[bramAddress[9:0]]   <= bramDataIn;
        wflag[bramAddress[9:0]] <= 1'b1;
      end else begin
        bramDataOut <= wflag[bramAddress[9:0]] ? mem[bramAddress[9:0]]
                                               : (16'hA000 + {6'd0, bramAddress[9:0]});
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Streaming bookkeeping
  int       runLen[$];
  logic     runOwn[$];
  int       p0, p1, wait1, max1;
  logic     a0, a1, prv0, prv1;
  logic [WL-1:0] exp0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  int   expLen[5] = '{8, 8, 8, 8, 4};
  logic expOwn[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam int EXP_RUNS = 5;
`else
  int   expLen[2] = '{20, 16};
  logic expOwn[2] = '{1'b0, 1'b1};
  localparam int EXP_RUNS = 2;
`endif

  initial begin
    resetN   = 1'b0;
    reqValid = 2'b11;
    reqWrite = 2'b00;
    reqAddr0 = '0;
    reqAddr1 = '0;
    reqData0 = '0;
    reqData1 = '0;

    // ---- reset held 3 cycles with both ports requesting
    repeat (3) begin
      step();
      sample();
      chk("rst_ready", reqReady, 2'b00);
      chk("rst_rsp", {rspValid, rspErr}, 4'b0000);
      chk("rst_bram", {bramEnable, bramWriteEnable}, 2'b00);
      chk("rst_zero", {rspData, bramDataIn}, 32'h0);
      chk("rst_addr", bramAddress, 0);
    end
    step();
    resetN = 1'b1;
    sample();
    chk("rel_ready_c1", reqReady, 2'b00);
    sample();
    chk("rel_ready_c2", reqReady, 2'b01);
    step();
    reqValid = 2'b00;
    repeat (3) step();

    // ---- port 0 write 0xBEEF @ 0x10, then read it back
    reqValid = 2'b01;
    reqWrite = 2'b01;
    reqAddr0 = 17'h00010;
    reqData0 = 16'hBEEF;
    sample();
    chk("wr_idle_ready", reqReady, 2'b00);
    chk("wr_idle_en", bramEnable, 1'b0);
    sample();
    chk("wr_ready", reqReady, 2'b01);
    chk("wr_en_we", {bramEnable, bramWriteEnable}, 2'b11);
    chk("wr_addr", bramAddress, 32'h10);
    chk("wr_din", bramDataIn, 32'hBEEF);
    step();
    reqWrite = 2'b00;
    sample();
    chk("rd_en_we", {bramEnable, bramWriteEnable}, 2'b10);
    chk("rd_addr", bramAddress, 32'h10);
    chk("wr_no_rsp", rspValid, 2'b00);
    step();
    reqValid = 2'b00;
    sample();
    chk("rd_rsp_valid", rspValid, 2'b01);
    chk("rd_rsp_data", rspData, 32'hBEEF);
    chk("rd_rsp_err", rspErr, 2'b00);
    repeat (2) step();

    // ---- port 1: last legal address, then first illegal address
    reqValid = 2'b10;
    reqAddr1 = 17'd125000;
    sample();
    sample();
    chk("edge_ready", reqReady, 2'b10);
    chk("edge_en", bramEnable, 1'b1);
    chk("edge_addr", bramAddress, 32'd125000);
    step();
    reqAddr1 = 17'd125001;
    sample();
    chk("oor_en", bramEnable, 1'b0);
    chk("edge_rsp_vld", rspValid, 2'b10);
    chk("edge_rsp_data", rspData, 32'hA048);
    chk("edge_rsp_err", rspErr, 2'b00);
    step();
    reqValid = 2'b00;
    sample();
    chk("oor_err", rspErr, 2'b10);
    chk("oor_vld", rspValid, 2'b10);
    chk("oor_data", rspData, 32'h0);
    repeat (2) step();

    // ---- port 0 streams 20 reads, port 1 requests 16 reads
    p0 = 0; p1 = 0; wait1 = 0; max1 = 0;
    prv0 = 1'b0; prv1 = 1'b0; exp0 = '0;
    reqWrite = 2'b00;
    reqAddr0 = 17'h00100;
    reqAddr1 = 17'h00200;
    reqValid = 2'b11;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      a0 = reqValid[0] & reqReady[0];
      a1 = reqValid[1] & reqReady[1];
      if (prv0 | prv1) begin
        chk("str_rsp_vld", rspValid, {prv1, prv0});
        chk("str_rsp_data", rspData, prv0 ? exp0 : 16'hA200);
      end
      if (a0 | a1) begin
        if (runLen.size() > 0 && runOwn[runOwn.size()-1] == a1) begin
          runLen[runLen.size()-1]++;
        end else begin
          runLen.push_back(1);
          runOwn.push_back(a1);
        end
      end
      if (reqValid[1] && !reqReady[1]) wait1++;
      else wait1 = 0;
      if (wait1 > max1) max1 = wait1;
      prv0 = a0;
      prv1 = a1;
      if (a0) exp0 = 16'hA000 + reqAddr0[15:0];
      @(posedge clock);
      #1;
      if (a0) begin
        p0++;
        reqAddr0 = reqAddr0 + 17'd1;
        if (p0 == 20) reqValid[0] = 1'b0;
      end
      if (a1) begin
        p1++;
        if (p1 == 16) reqValid[1] = 1'b0;
      end
    end
    reqValid = 2'b00;
    chk("str_p0_beats", p0, 20);
    chk("str_p1_beats", p1, 16);
    chk("str_nruns", runLen.size(), EXP_RUNS);
    for (int i = 0; i < runLen.size() && i < EXP_RUNS; i++) begin
      chk($sformatf("str_run%0d_len", i), runLen[i], expLen[i]);
      chk($sformatf("str_run%0d_own", i), runOwn[i], expOwn[i]);
    end
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    chk("rr_max_wait1", max1, 9);
`endif
    repeat (3) step();

    // ---- reset in the cycle after an accepted read
    reqValid = 2'b01;
    reqAddr0 = 17'h00020;
    sample();
    sample();
    chk("rstp_ready", reqReady, 2'b01);
    step();
    resetN   = 1'b0;
    reqValid = 2'b00;
    sample();
    chk("rstp_vld", rspValid, 2'b00);
    chk("rstp_data", rspData, 32'h0);
    step();
    sample();
    chk("rstp_state", dut.state_q, IDLE);
    chk("rstp_vld2", rspValid, 2'b00);
    step();
    resetN = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
